mesh_noc_4x4: RTL and testbench



---
 rtl/noc_pkg.sv | 40 ++++
 rtl/noc_router.sv | 133 +++++++++++++
 rtl/mesh_noc_4x4.sv | 117 +++++++++++
 tb/tb_mesh_noc_4x4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the 4x4 mesh NoC.
// Contents: mesh and buffer constants, the 24-bit link flit layout,
// the router port enumeration and the XY route function.
package noc_pkg;

    localparam int MESH_DIM   = 4;
    localparam int N_NODES    = MESH_DIM * MESH_DIM;
    localparam int N_PKTS     = 30;
    localparam int FIFO_DEPTH = 2;
    localparam int RX_DEPTH   = 32;
    localparam int N_PORTS    = 5;

    // Link flit: {dest, payload, src}. The logged word is {payload, src}.
    typedef struct packed {
        logic [3:0]  dest;
        logic [15:0] payload;
        logic [3:0]  src;
    } flit_t;

    typedef enum logic [2:0] {
        P_L = 3'd0,
        P_N = 3'd1,
        P_E = 3'd2,
        P_S = 3'd3,
        P_W = 3'd4
    } port_e;

    // Dimension-ordered routing: resolve x first, then y (y grows southward).
    // Node id layout is id = {y, x}.
    function automatic port_e xy_route(input logic [3:0] cur, input logic [3:0] dest);
        port_e p;
        if (dest[1:0] > cur[1:0])      p = P_E;
        else if (dest[1:0] < cur[1:0]) p = P_W;
        else if (dest[3:2] > cur[3:2]) p = P_S;
        else if (dest[3:2] < cur[3:2]) p = P_N;
        else                           p = P_L;
        return p;
    endfunction

endpackage

// File: rtl/noc_router.sv
// 5-port mesh router: one FIFO per input, XY route from the head flit,
// one round-robin arbiter per output and a combinational crossbar.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      per-port incoming flits
//   in_ready              per-port FIFO-not-full
//   out_valid/out_data    per-port outgoing flits (from granted FIFO head)
//   out_ready             per-port downstream ready
module noc_router
    import noc_pkg::*;
#(
    parameter logic [3:0] NODE_ID = 4'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PORTS-1:0]  in_valid,
    input  flit_t [N_PORTS-1:0] in_data,
    output logic [N_PORTS-1:0]  in_ready,
    output logic [N_PORTS-1:0]  out_valid,
    output flit_t [N_PORTS-1:0] out_data,
    input  logic [N_PORTS-1:0]  out_ready
);

    // Pointer width; wrap relies on FIFO_DEPTH being a power of two.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

    logic [N_PORTS-1:0]  not_empty;
    logic [N_PORTS-1:0]  pop;
    flit_t [N_PORTS-1:0] head;
    port_e               dir [N_PORTS];
    logic [2:0]          grant_idx [N_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_fifo
            flit_t       mem_reg [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [PW:0]   count_reg;
            logic          push;

            // Ready reflects only the current fill level: a full FIFO refuses a
            // push even in a cycle where it is also popped.
            assign in_ready[gi]  = (count_reg != CNT_FULL);
            assign push          = in_valid[gi] && in_ready[gi];
            assign not_empty[gi] = (count_reg != '0);
            assign head[gi]      = mem_reg[rd_ptr_reg];
            assign dir[gi]       = xy_route(NODE_ID, mem_reg[rd_ptr_reg].dest);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        mem_reg[wr_ptr_reg] <= in_data[gi];
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    if (push && !pop[gi])      count_reg <= count_reg + (PW+1)'(1);
                    else if (!push && pop[gi]) count_reg <= count_reg - (PW+1)'(1);
                end
            end
        end

        for (gi = 0; gi < N_PORTS; gi++) begin : g_arb
            logic [N_PORTS-1:0] req;
            logic [2:0]         ptr_reg;
            logic               hold_reg;
            logic [2:0]         hold_idx_reg;
            logic [2:0]         grant;
            logic               grant_vld;

            always_comb begin
                req = '0;
                for (int i = 0; i < N_PORTS; i++)
                    req[i] = not_empty[i] && (dir[i] == port_e'(3'(gi)));
            end

            // A stalled grant is kept for the next cycle so the output word
            // stays stable while downstream is not ready; otherwise the first
            // requester at or after ptr_reg wins.
            always_comb begin
                logic [3:0] sum;
                logic [2:0] idx;
                sum       = '0;
                idx       = '0;
                grant     = ptr_reg;
                grant_vld = 1'b0;
                if (hold_reg) begin
                    grant     = hold_idx_reg;
                    grant_vld = req[hold_idx_reg];
                end else begin
                    for (int j = N_PORTS - 1; j >= 0; j--) begin
                        sum = {1'b0, ptr_reg} + 4'(j);
                        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                        if (req[idx]) begin
                            grant     = idx;
                            grant_vld = 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_reg      <= '0;
                    hold_reg     <= 1'b0;
                    hold_idx_reg <= '0;
                end else begin
                    hold_reg     <= grant_vld && !out_ready[gi];
                    hold_idx_reg <= grant;
                    if (grant_vld && out_ready[gi])
                        ptr_reg <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
                end
            end

            assign out_valid[gi] = grant_vld;
            assign out_data[gi]  = head[grant];
            assign grant_idx[gi] = grant;
        end
    endgenerate

    // A head routes to exactly one output, so each FIFO pops at most once.
    always_comb begin
        pop = '0;
        for (int o = 0; o < N_PORTS; o++)
            if (out_valid[o] && out_ready[o]) pop[grant_idx[o]] = 1'b1;
    end

endmodule

// File: rtl/mesh_noc_4x4.sv
// Self-contained 4x4 mesh NoC: 16 routers, each with a traffic-generating PE
// that injects a fixed 30-packet pattern and logs ejected packets to rx_mem.
// Ports:
//   clk  system clock
//   RST  asynchronous active-low reset
// Results are read hierarchically from rx_mem / wptr_reg.
module mesh_noc_4x4
    import noc_pkg::*;
(
    input logic clk,
    input logic RST
);

    logic [N_PORTS-1:0]  r_in_valid  [N_NODES];
    flit_t [N_PORTS-1:0] r_in_data   [N_NODES];
    logic [N_PORTS-1:0]  r_in_ready  [N_NODES];
    logic [N_PORTS-1:0]  r_out_valid [N_NODES];
    flit_t [N_PORTS-1:0] r_out_data  [N_NODES];
    logic [N_PORTS-1:0]  r_out_ready [N_NODES];

    logic [4:0]  k_reg    [N_NODES];
    logic [5:0]  wptr_reg [N_NODES];
    logic [19:0] rx_mem   [N_NODES][RX_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < N_NODES; gi++) begin : g_node
            localparam int X = gi % MESH_DIM;
            localparam int Y = gi / MESH_DIM;

            logic [3:0] k_mod;
            flit_t      pe_flit;

            // dest = s + 1 + (k mod 15) in 4-bit arithmetic never equals s.
            assign k_mod = (k_reg[gi] >= 5'd15) ? 4'(k_reg[gi] - 5'd15) : k_reg[gi][3:0];
            assign pe_flit.dest    = 4'(gi) + 4'd1 + k_mod;
            assign pe_flit.payload = {4'h8, 4'(gi), 3'b000, k_reg[gi]};
            assign pe_flit.src     = 4'(gi);

            assign r_in_valid[gi][P_L]  = (k_reg[gi] < 5'(N_PKTS));
            assign r_in_data[gi][P_L]   = pe_flit;
            assign r_out_ready[gi][P_L] = 1'b1;

            if (Y > 0) begin : g_n
                assign r_in_valid[gi][P_N]  = r_out_valid[gi-MESH_DIM][P_S];
                assign r_in_data[gi][P_N]   = r_out_data[gi-MESH_DIM][P_S];
                assign r_out_ready[gi][P_N] = r_in_ready[gi-MESH_DIM][P_S];
            end else begin : g_n_edge
                assign r_in_valid[gi][P_N]  = 1'b0;
                assign r_in_data[gi][P_N]   = '0;
                assign r_out_ready[gi][P_N] = 1'b0;
            end

            if (Y < MESH_DIM - 1) begin : g_s
                assign r_in_valid[gi][P_S]  = r_out_valid[gi+MESH_DIM][P_N];
                assign r_in_data[gi][P_S]   = r_out_data[gi+MESH_DIM][P_N];
                assign r_out_ready[gi][P_S] = r_in_ready[gi+MESH_DIM][P_N];
            end else begin : g_s_edge
                assign r_in_valid[gi][P_S]  = 1'b0;
                assign r_in_data[gi][P_S]   = '0;
                assign r_out_ready[gi][P_S] = 1'b0;
            end

            if (X < MESH_DIM - 1) begin : g_e
                assign r_in_valid[gi][P_E]  = r_out_valid[gi+1][P_W];
                assign r_in_data[gi][P_E]   = r_out_data[gi+1][P_W];
                assign r_out_ready[gi][P_E] = r_in_ready[gi+1][P_W];
            end else begin : g_e_edge
                assign r_in_valid[gi][P_E]  = 1'b0;
                assign r_in_data[gi][P_E]   = '0;
                assign r_out_ready[gi][P_E] = 1'b0;
            end

            if (X > 0) begin : g_w
                assign r_in_valid[gi][P_W]  = r_out_valid[gi-1][P_E];
                assign r_in_data[gi][P_W]   = r_out_data[gi-1][P_E];
                assign r_out_ready[gi][P_W] = r_in_ready[gi-1][P_E];
            end else begin : g_w_edge
                assign r_in_valid[gi][P_W]  = 1'b0;
                assign r_in_data[gi][P_W]   = '0;
                assign r_out_ready[gi][P_W] = 1'b0;
            end

            noc_router #(.NODE_ID(4'(gi))) u_router (
                .clk       (clk),
                .rst_n     (RST),
                .in_valid  (r_in_valid[gi]),
                .in_data   (r_in_data[gi]),
                .in_ready  (r_in_ready[gi]),
                .out_valid (r_out_valid[gi]),
                .out_data  (r_out_data[gi]),
                .out_ready (r_out_ready[gi])
            );
        end
    endgenerate

    // PE injection counters and ejection logging; wptr saturates at RX_DEPTH.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int n = 0; n < N_NODES; n++) begin
                k_reg[n]    <= '0;
                wptr_reg[n] <= '0;
                for (int j = 0; j < RX_DEPTH; j++) rx_mem[n][j] <= '0;
            end
        end else begin
            for (int n = 0; n < N_NODES; n++) begin
                if (r_in_valid[n][P_L] && r_in_ready[n][P_L])
                    k_reg[n] <= k_reg[n] + 5'd1;
                if (r_out_valid[n][P_L] && (wptr_reg[n] != 6'(RX_DEPTH))) begin
                    rx_mem[n][wptr_reg[n][4:0]] <= {r_out_data[n][P_L].payload, r_out_data[n][P_L].src};
                    wptr_reg[n] <= wptr_reg[n] + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_noc_4x4.sv
module tb_mesh_noc_4x4;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mesh_noc_4x4 dut (
        .clk (clk),
        .RST (RST)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Everything in reset: no router output valid, all logs and pointers zero.
    task automatic check_cleared(input string phase);
        for (int n = 0; n < N_NODES; n++) begin
            logic [19:0] acc;
            acc = '0;
            for (int j = 0; j < RX_DEPTH; j++) acc = acc | dut.rx_mem[n][j];
            check($sformatf("%s n%0d wptr", phase, n), 32'(dut.wptr_reg[n]), 32'd0);
            check($sformatf("%s n%0d rx_mem", phase, n), 32'(acc), 32'd0);
            check($sformatf("%s n%0d out_valid", phase, n), 32'(dut.r_out_valid[n]), 32'd0);
        end
        $display("[%0t] %s: reset state checked on all nodes", $time, phase);
    endtask

    // Reference: node d must hold exactly the packets (s,k) whose
    // dest = (s + 1 + k%15) % 16 equals d, each once, with payload 0x8000|s<<8|k.
    task automatic verify_full(input string phase);
        bit seen [N_NODES][N_PKTS];
        int total;
        total = 0;
        for (int s = 0; s < N_NODES; s++)
            for (int k = 0; k < N_PKTS; k++) seen[s][k] = 1'b0;
        for (int d = 0; d < N_NODES; d++) begin
            int got;
            got = 0;
            check($sformatf("%s n%0d wptr", phase, d), 32'(dut.wptr_reg[d]), 32'(N_PKTS));
            for (int j = 0; j < N_PKTS; j++) begin
                logic [19:0] w;
                int src, kk, exp_pl;
                bit ok;
                w      = dut.rx_mem[d][j];
                src    = int'(w[3:0]);
                kk     = int'(w[8:4]);
                exp_pl = 32'h8000 | (src << 8) | kk;
                ok = (kk < N_PKTS) && (int'(w[19:4]) == exp_pl) &&
                     (((src + 1 + (kk % 15)) % 16) == d);
                if (ok && !seen[src][kk]) begin
                    seen[src][kk] = 1'b1;
                    total++;
                    got++;
                end else begin
                    ok = 1'b0;
                end
                check($sformatf("%s n%0d entry%0d word=%05h", phase, d, j, w), 32'(ok), 32'd1);
            end
            check($sformatf("%s n%0d entry30", phase, d), 32'(dut.rx_mem[d][30]), 32'd0);
            check($sformatf("%s n%0d entry31", phase, d), 32'(dut.rx_mem[d][31]), 32'd0);
            $display("[%0t] %s: node %0d logged %0d valid packets", $time, phase, d, got);
        end
        check($sformatf("%s total", phase), 32'(total), 32'd480);
    endtask

    task automatic check_node0(input string phase);
        bit f1, f2;
        f1 = 1'b0;
        f2 = 1'b0;
        for (int j = 0; j < N_PKTS; j++) begin
            if (dut.rx_mem[0][j] == 20'h810E1) f1 = 1'b1;
            if (dut.rx_mem[0][j] == 20'h811D1) f2 = 1'b1;
        end
        check($sformatf("%s n0 has 810E1", phase), 32'(f1), 32'd1);
        check($sformatf("%s n0 has 811D1", phase), 32'(f2), 32'd1);
    endtask

    // Node 5 east output: a stalled flit must stay presented unchanged.
    logic  prev_ok = 1'b0;
    logic  prev_v  = 1'b0;
    logic  prev_r  = 1'b0;
    flit_t prev_d  = '0;
    bit    seen_local = 1'b0;
    bit    seen_west  = 1'b0;

    always @(negedge clk) begin
        logic  v, r;
        flit_t d;
        v = dut.r_out_valid[5][P_E];
        r = dut.r_out_ready[5][P_E];
        d = dut.r_out_data[5][P_E];
        if (RST && prev_ok && prev_v && !prev_r) begin
            check("n5E stall valid", 32'(v), 32'd1);
            check("n5E stall data", 32'(d), 32'(prev_d));
        end
        if (RST && v && r) begin
            if (d.src == 4'd5) seen_local = 1'b1;
            else               seen_west  = 1'b1;
        end
        prev_ok = RST;
        prev_v  = v;
        prev_r  = r;
        prev_d  = d;
    end

    initial begin
        int wait_cyc;
        bit arrived;
        int rcyc, rlen;

        // Reset held for 10 cycles.
        RST = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_cleared("initial reset");

        // Release and watch the first hop node 0 -> node 1.
        RST = 1'b1;
        arrived = 1'b0;
        wait_cyc = 0;
        while (!arrived && wait_cyc < 5) begin
            @(posedge clk);
            @(negedge clk);
            wait_cyc++;
            if (dut.wptr_reg[1] != 6'd0) arrived = 1'b1;
        end
        check("first hop arrived within 5", 32'(arrived), 32'd1);
        check("first hop word", 32'(dut.rx_mem[1][0]), 32'h80000);
        $display("[%0t] first hop: node1 entry0=%05h after %0d cycles", $time, dut.rx_mem[1][0], wait_cyc);

        repeat (400 - wait_cyc) @(posedge clk);
        @(negedge clk);
        verify_full("clean");
        check_node0("clean");

        // Restart, then reset at cycle 60 for 3 cycles (asynchronous edge).
        #($urandom_range(1, 4));
        RST = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        repeat (60) @(posedge clk);
        #($urandom_range(1, 4));
        RST = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("mid reset");
        RST = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        verify_full("after mid reset");
        check_node0("after mid reset");

        // Randomized reset point and length.
        rcyc = int'($urandom_range(10, 150));
        rlen = int'($urandom_range(1, 5));
        $display("[%0t] random reset at cycle %0d for %0d cycles", $time, rcyc, rlen);
        #($urandom_range(1, 4));
        RST = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        repeat (rcyc) @(posedge clk);
        #($urandom_range(1, 9));
        RST = 1'b0;
        repeat (rlen) @(posedge clk);
        @(negedge clk);
        check_cleared("random reset");
        RST = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        verify_full("after random reset");

        check("n5E carried local traffic", 32'(seen_local), 32'd1);
        check("n5E carried west traffic", 32'(seen_west), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
